// File: rtl/muldiv_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_seq_if
// Description : Request/result bundle between the pipeline and the
//               sequential multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface muldiv_seq_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [1:0]       Op;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic             HiWe;
  logic             LoWe;
  logic [WIDTH-1:0] WrData;
  logic             Busy;
  logic             Done;
  logic             DivZero;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;

  modport master (
    output Start, Op, SrcA, SrcB, HiWe, LoWe, WrData,
    input  Busy, Done, DivZero, Hi, Lo
  );

  modport slave (
    input  Start, Op, SrcA, SrcB, HiWe, LoWe, WrData,
    output Busy, Done, DivZero, Hi, Lo
  );
endinterface
`default_nettype wire

// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_seq
// Description : 33-cycle sequential MULT/MULTU/DIV/DIVU unit with HI/LO
//               registers and mthi/mtlo write port.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  muldiv_seq_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t             r_state;
  logic [5:0]         r_cnt;
  logic               r_is_div;
  logic               r_sign_a;
  logic               r_sign_b;
  logic [WIDTH-1:0]   r_a_raw;
  logic [WIDTH-1:0]   r_b;
  logic [2*WIDTH-1:0] r_p;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_busy;
  logic               r_done;
  logic               r_divzero;

  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH:0]     w_rem;
  logic               w_ge;
  logic [WIDTH-1:0]   w_sub;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_mul_step;
  logic [2*WIDTH-1:0] w_div_step;
  logic               w_neg;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rmd;
  logic               w_div0;

  always_comb begin
    // Signed ops iterate on magnitudes; unsigned ops use the raw operands.
    w_mag_a = bus.SrcA;
    if (bus.Op[0] && bus.SrcA[WIDTH-1]) w_mag_a = -bus.SrcA;
    w_mag_b = bus.SrcB;
    if (bus.Op[0] && bus.SrcB[WIDTH-1]) w_mag_b = -bus.SrcB;

    // Multiply: r_p = {partial product, remaining multiplier bits}.
    w_sum      = {1'b0, r_p[2*WIDTH-1:WIDTH]} + {1'b0, r_b};
    w_mul_step = r_p[0] ? {w_sum, r_p[WIDTH-1:1]}
                        : {1'b0, r_p[2*WIDTH-1:WIDTH], r_p[WIDTH-1:1]};

    // Divide: r_p = {partial remainder, dividend bits / quotient bits}.
    // The shifted remainder can need WIDTH+1 bits, but whenever the
    // subtraction succeeds the difference fits back into WIDTH bits.
    w_rem      = r_p[2*WIDTH-1:WIDTH-1];
    w_ge       = (w_rem >= {1'b0, r_b});
    w_sub      = w_rem[WIDTH-1:0] - r_b;
    w_div_step = w_ge ? {w_sub, r_p[WIDTH-2:0], 1'b1}
                      : {w_rem[WIDTH-1:0], r_p[WIDTH-2:0], 1'b0};

    w_neg  = r_sign_a ^ r_sign_b;
    w_prod = r_p;
    if (w_neg) w_prod = -r_p;
    w_quo  = r_p[WIDTH-1:0];
    if (w_neg) w_quo = -r_p[WIDTH-1:0];
    w_rmd  = r_p[2*WIDTH-1:WIDTH];
    if (r_sign_a) w_rmd = -r_p[2*WIDTH-1:WIDTH];

    w_div0 = r_is_div && (r_b == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_is_div  <= 1'b0;
      r_sign_a  <= 1'b0;
      r_sign_b  <= 1'b0;
      r_a_raw   <= '0;
      r_b       <= '0;
      r_p       <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_divzero <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_divzero <= 1'b0;
      case (r_state)
        IDLE: begin
          // Start takes priority over a simultaneous mthi/mtlo write.
          if (bus.Start) begin
            r_is_div <= bus.Op[1];
            r_sign_a <= bus.Op[0] & bus.SrcA[WIDTH-1];
            r_sign_b <= bus.Op[0] & bus.SrcB[WIDTH-1];
            r_a_raw  <= bus.SrcA;
            r_b      <= w_mag_b;
            r_p      <= {{WIDTH{1'b0}}, w_mag_a};
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= CALC;
          end else begin
            if (bus.HiWe) r_hi <= bus.WrData;
            if (bus.LoWe) r_lo <= bus.WrData;
          end
        end
        CALC: begin
          r_p   <= r_is_div ? w_div_step : w_mul_step;
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == 6'(WIDTH - 1)) r_state <= FIX;
        end
        FIX: begin
          if (w_div0) begin
            r_hi <= r_a_raw;
            r_lo <= '1;
          end else if (r_is_div) begin
            r_hi <= w_rmd;
            r_lo <= w_quo;
          end else begin
            r_hi <= w_prod[2*WIDTH-1:WIDTH];
            r_lo <= w_prod[WIDTH-1:0];
          end
          r_done    <= 1'b1;
          r_divzero <= w_div0;
          r_busy    <= 1'b0;
          r_state   <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.Busy    = r_busy;
  assign bus.Done    = r_done;
  assign bus.DivZero = r_divzero;
  assign bus.Hi      = r_hi;
  assign bus.Lo      = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_seq
// Description : Self-checking bench for muldiv_seq against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_seq;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_err;

  muldiv_seq_if #(.WIDTH(32)) bus ();

  muldiv_seq #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Architectural result of one operation: {DivZero, Hi, Lo}.
  function automatic logic [64:0] ref_op(input logic [1:0] op,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, p;
    logic [63:0] up;
    int ia, ib;
    ref_op = '0;
    case (op)
      2'b00: begin
        up = {32'b0, a} * {32'b0, b};
        ref_op = {1'b0, up};
      end
      2'b01: begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = sa * sb;
        ref_op = {1'b0, 64'(p)};
      end
      2'b10: begin
        if (b == 0) ref_op = {1'b1, a, 32'hFFFF_FFFF};
        else        ref_op = {1'b0, a % b, a / b};
      end
      default: begin
        ia = a;
        ib = b;
        if (b == 0)                                    ref_op = {1'b1, a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ref_op = {1'b0, 32'h0, 32'h8000_0000};
        else                                           ref_op = {1'b0, 32'(ia % ib), 32'(ia / ib)};
      end
    endcase
  endfunction

  // Cycle-level expectation: a result appears 33 edges after an accepted Start.
  logic        m_busy, m_done, m_dz;
  logic [31:0] m_hi, m_lo;
  logic [64:0] m_pend;
  int          m_left;

  initial begin
    m_busy = 0; m_done = 0; m_dz = 0; m_hi = 0; m_lo = 0; m_pend = 0; m_left = 0;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_done = 0; m_dz = 0; m_hi = 0; m_lo = 0; m_left = 0;
    end else begin
      m_done = 0;
      m_dz   = 0;
      if (m_busy) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          {m_dz, m_hi, m_lo} = m_pend;
          m_done = 1;
          m_busy = 0;
        end
      end else if (bus.Start) begin
        m_pend = ref_op(bus.Op, bus.SrcA, bus.SrcB);
        m_busy = 1;
        m_left = 33;
      end else begin
        if (bus.HiWe) m_hi = bus.WrData;
        if (bus.LoWe) m_lo = bus.WrData;
      end
    end
  end

  always @(negedge clk) begin
    n_checks++;
    if ({bus.Busy, bus.Done, bus.DivZero, bus.Hi, bus.Lo} !== {m_busy, m_done, m_dz, m_hi, m_lo}) begin
      n_err++;
      $display("FAIL cycle_compare t=%0t actual busy=%b done=%b dz=%b hi=%h lo=%h required busy=%b done=%b dz=%b hi=%h lo=%h",
               $time, bus.Busy, bus.Done, bus.DivZero, bus.Hi, bus.Lo, m_busy, m_done, m_dz, m_hi, m_lo);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Issue one op, optionally poke Start+HiWe mid-calculation, check the result.
  task automatic run_op(input string name, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic lowe, input logic [31:0] wd, input logic junk,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input logic exp_dz);
    int busy_cnt;
    logic got;
    bus.Start = 1; bus.Op = op; bus.SrcA = a; bus.SrcB = b;
    bus.LoWe = lowe; bus.WrData = wd;
    @(negedge clk);
    bus.Start = 0; bus.LoWe = 0;
    bus.Op = ~op; bus.SrcA = $urandom; bus.SrcB = $urandom;
    busy_cnt = bus.Busy ? 1 : 0;
    got = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (junk && i == 5) begin
        bus.Start = 1; bus.HiWe = 1; bus.WrData = 32'hDEAD_BEEF;
      end else begin
        bus.Start = 0; bus.HiWe = 0;
      end
      if (bus.Done) begin
        got = 1;
        break;
      end
      if (bus.Busy) busy_cnt++;
    end
    bus.Start = 0; bus.HiWe = 0;
    chk({name, "_done_seen"}, 64'(got), 64'd1);
    chk({name, "_busy_cycles"}, 64'(busy_cnt), 64'd33);
    chk({name, "_hi"}, 64'(bus.Hi), 64'(exp_hi));
    chk({name, "_lo"}, 64'(bus.Lo), 64'(exp_lo));
    chk({name, "_divzero"}, 64'(bus.DivZero), 64'(exp_dz));
    @(negedge clk);
    chk({name, "_done_one_cycle"}, 64'(bus.Done), 64'd0);
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom % 8)
      0:       rnd_operand = 32'h0;
      1:       rnd_operand = 32'h8000_0000;
      2:       rnd_operand = 32'hFFFF_FFFF;
      3:       rnd_operand = 32'h1;
      4:       rnd_operand = $urandom % 16;
      5:       rnd_operand = -($urandom % 16);
      default: rnd_operand = $urandom;
    endcase
  endfunction

  initial begin
    n_checks = 0;
    n_err    = 0;
    bus.Start = 0; bus.Op = 0; bus.SrcA = 0; bus.SrcB = 0;
    bus.HiWe = 0; bus.LoWe = 0; bus.WrData = 0;
    rst_n = 1;
    #1 rst_n = 0;
    #1;
    chk("reset_state", {27'b0, bus.Busy, bus.Done, bus.DivZero, bus.Hi != 0, bus.Lo != 0}, 64'd0);
    @(negedge clk);
    #2 rst_n = 1;

    // First Start right after release must be accepted.
    run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 32'hFFFF_FFFE, 32'h0000_0001, 0);
    run_op("mult_neg",  2'b01, 32'hFFFF_FFFD, 32'd7, 0, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);
    run_op("div_neg",   2'b11, 32'hFFFF_FFF9, 32'd2, 0, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
    run_op("divu_zero", 2'b10, 32'd5, 32'd0, 0, 0, 0, 32'h0000_0005, 32'hFFFF_FFFF, 1);
    run_op("div_wrap",  2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 32'h0, 32'h8000_0000, 0);
    run_op("div_zero",  2'b11, 32'hFFFF_FFF9, 32'd0, 0, 0, 0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1);
    run_op("busy_poke", 2'b00, 32'h0001_0000, 32'h0001_0000, 0, 0, 1, 32'h1, 32'h0, 0);
    run_op("start_lowe", 2'b00, 32'd2, 32'd3, 1, 32'h1234, 0, 32'h0, 32'h6, 0);

    // mthi/mtlo together in IDLE.
    bus.HiWe = 1; bus.LoWe = 1; bus.WrData = 32'hCAFE_F00D;
    @(negedge clk);
    bus.HiWe = 0; bus.LoWe = 0;
    chk("mthi_mtlo", {bus.Hi, bus.Lo}, {32'hCAFE_F00D, 32'hCAFE_F00D});

    // Abort mid-calculation with reset.
    bus.Start = 1; bus.Op = 2'b00; bus.SrcA = 32'd7; bus.SrcB = 32'd9;
    @(negedge clk);
    bus.Start = 0;
    repeat (10) @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("abort_outputs", {28'b0, bus.Busy, bus.Done, bus.Hi != 0, bus.Lo != 0}, 64'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1;
    run_op("after_abort", 2'b00, 32'd7, 32'd9, 0, 0, 0, 32'h0, 32'd63, 0);

    // Randomized traffic, including Start/HiWe/LoWe while busy.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      bus.Start  = ($urandom % 6) == 0;
      bus.HiWe   = ($urandom % 5) == 0;
      bus.LoWe   = ($urandom % 5) == 0;
      bus.Op     = 2'($urandom);
      bus.SrcA   = rnd_operand();
      bus.SrcB   = rnd_operand();
      bus.WrData = $urandom;
    end
    bus.Start = 0; bus.HiWe = 0; bus.LoWe = 0;
    repeat (40) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
